id_ex_stage: RTL and testbench

- Decode and ID/EX pipeline register stage. It sits between the IF/ID register and the execute stage, wrapped around the register file.
- Drives the register-file read addresses and captures the returned operands.
- Generates sign-extended immediates and decodes control signals.
- Detects load-use hazards, inserting a one-cycle bubble and stalling IF/ID.
- Applies branch flushes.

---
 rtl/id_ex_if.sv | 51 +++++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Bundle of IF/ID inputs, register-file operands and ID/EX pipeline outputs for the decode stage.
// The stage connects through the slave modport; whoever feeds IF/ID and consumes EX uses master.
interface id_ex_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic [31:0]      if_id_inst;
    logic [XLEN-1:0]  if_id_pc;
    logic             if_id_valid;
    logic             branch_taken;
    logic [XLEN-1:0]  readData1;
    logic [XLEN-1:0]  readData2;

    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             stall;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rd1;
    logic [XLEN-1:0]  ex_rd2;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [3:0]       ex_funct4;
    logic             ex_RegWrite;
    logic             ex_MemRead;
    logic             ex_MemWrite;
    logic             ex_MemtoReg;
    logic             ex_Branch;
    logic             ex_ALUSrc;
    logic [1:0]       ex_ALUOp;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output if_id_inst, if_id_pc, if_id_valid, branch_taken, readData1, readData2,
        input  rs1, rs2, stall,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct4,
        input  ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_ALUSrc,
        input  ex_ALUOp, stall_count
    );

    modport slave (
        input  if_id_inst, if_id_pc, if_id_valid, branch_taken, readData1, readData2,
        output rs1, rs2, stall,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct4,
        output ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_ALUSrc,
        output ex_ALUOp, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register: operand capture, immediate generation,
// control decode, load-use bubble insertion and branch flush.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic    clk,
    input  logic    reset,
    id_ex_if.slave  bus
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } inst_class_t;

    logic [31:0]     inst;
    inst_class_t     inst_class;
    logic            supported;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            hazard;
    logic [XLEN-1:0] imm;

    logic            dec_alusrc;
    logic            dec_memtoreg;
    logic            dec_regwrite;
    logic            dec_memread;
    logic            dec_memwrite;
    logic            dec_branch;
    logic [1:0]      dec_aluop;

    assign inst = bus.if_id_inst;

    always_comb begin
        inst_class = CLS_NONE;
        case (inst[6:0])
            OP_RTYPE:  inst_class = CLS_RTYPE;
            OP_IALU:   inst_class = CLS_IALU;
            OP_LOAD:   inst_class = CLS_LOAD;
            OP_STORE:  inst_class = CLS_STORE;
            OP_BRANCH: inst_class = CLS_BRANCH;
            default:   inst_class = CLS_NONE;
        endcase
    end

    assign supported = (inst_class != CLS_NONE);

    always_comb begin
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_aluop    = 2'b00;
        case (inst_class)
            CLS_RTYPE: begin
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b10;
            end
            CLS_IALU: begin
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b11;
            end
            CLS_LOAD: begin
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
            end
            CLS_STORE: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
            end
            CLS_BRANCH: begin
                dec_branch   = 1'b1;
                dec_aluop    = 2'b01;
            end
            default: begin
                dec_aluop    = 2'b00;
            end
        endcase
    end

    // Branch immediates are byte offsets, so bit 0 is always zero.
    always_comb begin
        imm = '0;
        case (inst_class)
            CLS_IALU, CLS_LOAD:
                imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            CLS_STORE:
                imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            CLS_BRANCH:
                imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            default:
                imm = '0;
        endcase
    end

    assign uses_rs1 = supported;
    assign uses_rs2 = (inst_class == CLS_RTYPE) || (inst_class == CLS_STORE) ||
                      (inst_class == CLS_BRANCH);

    assign bus.rs1 = inst[19:15];
    assign bus.rs2 = inst[24:20];

    // A load to x0 never produces a value worth waiting for, hence the rd != 0 term.
    assign hazard = bus.ex_valid && bus.ex_MemRead && (bus.ex_rd != 5'd0) && bus.if_id_valid &&
                    (((bus.ex_rd == inst[19:15]) && uses_rs1) ||
                     ((bus.ex_rd == inst[24:20]) && uses_rs2));

    assign bus.stall = hazard && !bus.branch_taken && !reset;

    // Reset, flush and load-use bubble all load the same all-zero entry.
    always_ff @(posedge clk) begin
        if (reset || bus.branch_taken || hazard) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc       <= '0;
            bus.ex_rd1      <= '0;
            bus.ex_rd2      <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rs1      <= 5'd0;
            bus.ex_rs2      <= 5'd0;
            bus.ex_rd       <= 5'd0;
            bus.ex_funct4   <= 4'd0;
            bus.ex_RegWrite <= 1'b0;
            bus.ex_MemRead  <= 1'b0;
            bus.ex_MemWrite <= 1'b0;
            bus.ex_MemtoReg <= 1'b0;
            bus.ex_Branch   <= 1'b0;
            bus.ex_ALUSrc   <= 1'b0;
            bus.ex_ALUOp    <= 2'b00;
        end else begin
            bus.ex_valid    <= bus.if_id_valid && supported;
            bus.ex_pc       <= bus.if_id_pc;
            bus.ex_rd1      <= bus.readData1;
            bus.ex_rd2      <= bus.readData2;
            bus.ex_imm      <= imm;
            bus.ex_rs1      <= inst[19:15];
            bus.ex_rs2      <= inst[24:20];
            bus.ex_rd       <= inst[11:7];
            bus.ex_funct4   <= {inst[30], inst[14:12]};
            bus.ex_RegWrite <= bus.if_id_valid && dec_regwrite;
            bus.ex_MemRead  <= bus.if_id_valid && dec_memread;
            bus.ex_MemWrite <= bus.if_id_valid && dec_memwrite;
            bus.ex_MemtoReg <= bus.if_id_valid && dec_memtoreg;
            bus.ex_Branch   <= bus.if_id_valid && dec_branch;
            bus.ex_ALUSrc   <= bus.if_id_valid && dec_alusrc;
            bus.ex_ALUOp    <= bus.if_id_valid ? dec_aluop : 2'b00;
        end
    end

    // Flush-only cycles never reach the increment because stall already excludes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stall_count <= '0;
        end else if (bus.stall && (bus.stall_count != CNT_MAX)) begin
            bus.stall_count <= bus.stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 32-bit counter instance and a 4-bit one sharing stimulus.
module tb_id_ex_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_ex_if #(.XLEN(64), .CNT_W(32)) bus ();
    id_ex_if #(.XLEN(64), .CNT_W(4))  bus4 ();

    id_ex_stage #(.XLEN(64), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    id_ex_stage #(.XLEN(64), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    assign bus4.if_id_inst   = bus.if_id_inst;
    assign bus4.if_id_pc     = bus.if_id_pc;
    assign bus4.if_id_valid  = bus.if_id_valid;
    assign bus4.branch_taken = bus.branch_taken;
    assign bus4.readData1    = bus.readData1;
    assign bus4.readData2    = bus.readData2;

    logic [7:0] ctrl;
    assign ctrl = {bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead,
                   bus.ex_MemWrite, bus.ex_Branch, bus.ex_ALUOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] encR(input logic [4:0] rd, input logic [4:0] a,
                                         input logic [4:0] b);
        return {7'b0000000, b, a, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] a,
                                         input logic [11:0] imm);
        return {imm, a, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [4:0] a, input logic [4:0] b,
                                         input logic [11:0] imm);
        return {imm[11:5], b, a, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [4:0] a, input logic [4:0] b,
                                         input logic [12:0] imm);
        return {imm[12], imm[10:5], b, a, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] pc,
                                 input logic valid, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic br);
        bus.if_id_inst   = inst;
        bus.if_id_pc     = pc;
        bus.if_id_valid  = valid;
        bus.readData1    = d1;
        bus.readData2    = d2;
        bus.branch_taken = br;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus($urandom, {$urandom, $urandom}, 1'b1, {$urandom, $urandom},
                      {$urandom, $urandom}, 1'b0);
        step();
        applyStimulus($urandom, {$urandom, $urandom}, 1'b1, {$urandom, $urandom},
                      {$urandom, $urandom}, 1'b0);
        step();
        checkOutput("rst_valid", bus.ex_valid, 0);
        checkOutput("rst_pc", bus.ex_pc, 0);
        checkOutput("rst_imm", bus.ex_imm, 0);
        checkOutput("rst_ctrl", ctrl, 0);
        checkOutput("rst_stall", bus.stall, 0);
        checkOutput("rst_count", bus.stall_count, 0);

        reset = 1'b0;
        applyStimulus(encR(5'd3, 5'd1, 5'd2), 64'h1000, 1'b1, 64'd5, 64'd7, 1'b0);
        checkOutput("add_rs1", bus.rs1, 1);
        checkOutput("add_rs2", bus.rs2, 2);
        checkOutput("add_nostall", bus.stall, 0);
        step();
        checkOutput("add_rd1", bus.ex_rd1, 5);
        checkOutput("add_rd2", bus.ex_rd2, 7);
        checkOutput("add_rd", bus.ex_rd, 3);
        checkOutput("add_pc", bus.ex_pc, 64'h1000);
        checkOutput("add_ctrl", ctrl, 8'b0010_0010);
        checkOutput("add_valid", bus.ex_valid, 1);

        // ld x5,8(x1) followed by a dependent add x6,x5,x2
        applyStimulus(encI(OP_LD, 3'b011, 5'd5, 5'd1, 12'd8), 64'h1004, 1'b1, 0, 0, 1'b0);
        step();
        checkOutput("ld_ctrl", ctrl, 8'b1111_0000);
        checkOutput("ld_imm", bus.ex_imm, 8);
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 64'h1008, 1'b1, 0, 0, 1'b0);
        checkOutput("lu_stall", bus.stall, 1);
        step();
        checkOutput("lu_bubble", bus.ex_valid, 0);
        checkOutput("lu_bubctrl", ctrl, 0);
        checkOutput("lu_count", bus.stall_count, 1);
        checkOutput("lu_stall2", bus.stall, 0);
        step();
        checkOutput("lu_addvalid", bus.ex_valid, 1);
        checkOutput("lu_addrd", bus.ex_rd, 6);
        checkOutput("lu_count2", bus.stall_count, 1);

        // load to x0 must not stall
        applyStimulus(encI(OP_LD, 3'b011, 5'd0, 5'd1, 12'd0), 64'h100c, 1'b1, 0, 0, 1'b0);
        step();
        applyStimulus(encR(5'd6, 5'd0, 5'd2), 64'h1010, 1'b1, 0, 0, 1'b0);
        checkOutput("x0_nostall", bus.stall, 0);
        step();
        checkOutput("x0_valid", bus.ex_valid, 1);

        // addi x7,x6,5: inst[24:20] happens to be 5 but rs2 is unused
        applyStimulus(encI(OP_LD, 3'b011, 5'd5, 5'd1, 12'd0), 64'h1014, 1'b1, 0, 0, 1'b0);
        step();
        applyStimulus(encI(OP_ALUI, 3'b000, 5'd7, 5'd6, 12'd5), 64'h1018, 1'b1, 0, 0, 1'b0);
        checkOutput("addi_nostall", bus.stall, 0);
        step();
        checkOutput("addi_rd", bus.ex_rd, 7);
        checkOutput("addi_ctrl", ctrl, 8'b1010_0011);
        checkOutput("addi_imm", bus.ex_imm, 5);

        applyStimulus(encS(5'd1, 5'd2, 12'hFF8), 64'h101c, 1'b1, 0, 0, 1'b0);
        step();
        checkOutput("sd_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        checkOutput("sd_ctrl", ctrl, 8'b1000_1000);
        checkOutput("sd_funct4", bus.ex_funct4, 4'b1011);

        applyStimulus(encB(5'd1, 5'd2, 13'd16), 64'h1020, 1'b1, 0, 0, 1'b0);
        step();
        checkOutput("beq_imm", bus.ex_imm, 16);
        checkOutput("beq_ctrl", ctrl, 8'b0000_0101);

        // flush arriving together with a load-use hazard
        applyStimulus(encI(OP_LD, 3'b011, 5'd5, 5'd1, 12'd8), 64'h1024, 1'b1, 0, 0, 1'b0);
        step();
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 64'h1028, 1'b1, 0, 0, 1'b1);
        checkOutput("fl_stall", bus.stall, 0);
        step();
        checkOutput("fl_valid", bus.ex_valid, 0);
        checkOutput("fl_ctrl", ctrl, 0);
        checkOutput("fl_count", bus.stall_count, 1);

        applyStimulus(32'h0000_0073, 64'h102c, 1'b1, 64'd9, 64'd9, 1'b0);
        step();
        checkOutput("unsup_valid", bus.ex_valid, 0);
        checkOutput("unsup_ctrl", ctrl, 0);

        applyStimulus(encR(5'd3, 5'd1, 5'd2), 64'h1030, 1'b0, 0, 0, 1'b0);
        step();
        checkOutput("inv_valid", bus.ex_valid, 0);
        checkOutput("inv_ctrl", ctrl, 0);

        // reset arriving during a stall
        applyStimulus(encI(OP_LD, 3'b011, 5'd5, 5'd1, 12'd8), 64'h1034, 1'b1, 0, 0, 1'b0);
        step();
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 64'h1038, 1'b1, 0, 0, 1'b0);
        checkOutput("mr_stall", bus.stall, 1);
        reset = 1'b1;
        #1;
        checkOutput("mr_stallrst", bus.stall, 0);
        step();
        checkOutput("mr_valid", bus.ex_valid, 0);
        checkOutput("mr_count", bus.stall_count, 0);
        reset = 1'b0;

        // ld x5,0(x5) held: stalls every other cycle, 20 stalls in 40 cycles
        applyStimulus(encI(OP_LD, 3'b011, 5'd5, 5'd5, 12'd0), 64'h2000, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
        end
        checkOutput("sat_count32", bus.stall_count, 20);
        checkOutput("sat_count4", bus4.stall_count, 4'hF);
        step();
        step();
        checkOutput("sat_hold4", bus4.stall_count, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
